// File: rtl/m_imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Optional checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package m_imem_loader_pkg;

    typedef enum logic [2:0] {
        S_LEN0 = 3'd0,
        S_LEN1 = 3'd1,
        S_DATA = 3'd2,
        S_CSUM = 3'd3,
        S_DONE = 3'd4
    } state_e;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int BCNT_W     = $clog2(WORD_BYTES);

    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(WORD_BYTES - 1);

endpackage

// File: rtl/m_word_assembler.sv
// Little-endian byte-to-word assembler; first byte lands in bits 7:0.
// The assembled word and its complete strobe are presented in the accept cycle.
module m_word_assembler
    import m_imem_loader_pkg::*;
(
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_en,
    input  logic [7:0]  w_byte,
    output logic [31:0] word_o,
    output logic        done_o
);

    logic [31:0]       shift_q, shift_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;

    // Shift new byte in from the top so byte0 ends up in the low lane.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        word_o  = {w_byte, shift_q[31:8]};
        done_o  = w_en && (cnt_q == LAST_BYTE);
        if (w_en) begin
            shift_d = word_o;
            cnt_d   = cnt_q + 1'b1;
        end
    end

    // Shift register and byte counter.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/m_imem_loader.sv
// Length-prefixed program loader: writes words to imem, then releases the core.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module m_imem_loader
    import m_imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 12,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic [7:0]        w_rx_data,
    input  logic              w_rx_valid,
    output logic [ADDR_W-1:0] r_addr,
    output logic              r_we,
    output logic [31:0]       r_wdata,
    output logic              r_proc_rst,
    output logic              r_done,
    output logic              r_err
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_e FIN_STATE = S_CSUM;
`else
    localparam state_e FIN_STATE = S_DONE;
`endif

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [15:0]       wcnt_q, wcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              prst_q, prst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              asm_en;
    logic [31:0]       asm_word;
    logic              asm_done;
    logic [15:0]       len_full;
    logic              ovf;
    logic              last_word;

    assign asm_en    = w_rx_valid && (state_q == S_DATA);
    assign len_full  = {w_rx_data, len_q[7:0]};
    assign ovf       = 32'(wcnt_q) >= 32'(MAX_WORDS);
    assign last_word = wcnt_q == (len_q - 16'd1);

    m_word_assembler u_asm (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .w_en    (asm_en),
        .w_byte  (w_rx_data),
        .word_o  (asm_word),
        .done_o  (asm_done)
    );

    // Next-state, write strobe, overflow and release decisions.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        we_d    = 1'b0;
        wdata_d = wdata_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        unique case (state_q)
            S_LEN0: begin
                if (w_rx_valid) begin
                    len_d   = {8'h00, w_rx_data};
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (w_rx_valid) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = FIN_STATE;
                        done_d  = (FIN_STATE == S_DONE);
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (w_rx_valid) begin
                    csum_d = csum_q ^ w_rx_data;
                end
`endif
                if (asm_done) begin
                    wcnt_d = wcnt_q + 16'd1;
                    if (!ovf) begin
                        we_d    = 1'b1;
                        addr_d  = ADDR_W'(wcnt_q);
                        wdata_d = asm_word;
                    end else begin
                        err_d = 1'b1;
                    end
                    if (last_word) begin
                        state_d = FIN_STATE;
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_rx_valid) begin
                    if (w_rx_data != csum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
`endif
            S_DONE: begin
                done_d = 1'b1;
            end
            default: begin
                state_d = S_LEN0;
            end
        endcase
        prst_d = !(done_d && !err_d);
    end

    // State and output registers.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state_q <= S_LEN0;
            len_q   <= '0;
            wcnt_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            prst_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            prst_q  <= prst_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign r_addr     = addr_q;
    assign r_we       = we_q;
    assign r_wdata    = wdata_q;
    assign r_proc_rst = prst_q;
    assign r_done     = done_q;
    assign r_err      = err_q;

endmodule

// File: doc/m_imem_loader.md
Name: m_imem_loader

Overview:
- Byte-stream program loader sitting directly upstream of the multicycle processor and its instruction memory.
- Receives a length-prefixed program image from a UART receiver and assembles bytes into 32-bit words.
- Writes each word into instruction-memory word addresses starting at 0.
- Holds the processor in reset until the image is fully and correctly loaded, then releases it.

Parameters:
- ADDR_W, 12, instruction-memory word-address width; depth = 2^ADDR_W words (4096 at default).
- MAX_WORDS, 2^ADDR_W, largest word count accepted for writing.

Ports:
- w_clk  input  1  system clock
- w_rst_n  input  1  synchronous active-low reset
- w_rx_data  input  8  received byte
- w_rx_valid  input  1  one-cycle strobe, w_rx_data valid; no backpressure, loader accepts every strobe
- r_addr  output  ADDR_W  instruction-memory word write address
- r_we  output  1  instruction-memory write enable, one-cycle pulse
- r_wdata  output  32  instruction-memory write data
- r_proc_rst  output  1  active-high reset to processor
- r_done  output  1  load finished
- r_err  output  1  load error, sticky until reset

Behaviour:
- Reset: one clock and one reset; reset is synchronous and active-low (w_rst_n sampled on posedge w_clk).
  - Reset values: r_addr=0, r_we=0, r_wdata=0, r_proc_rst=1, r_done=0, r_err=0; state=S_LEN0; byte counter=0; word counter=0.
  - Reset applied mid-load discards any partial word and restarts the protocol.
  - A strobe in the same cycle as an active reset is ignored.
- Protocol, in byte order:
  - Two length bytes: count[7:0], then count[15:8].
  - Then count words, 4 bytes each, little-endian (byte0 -> bits 7:0).
- States:
  - S_LEN0: on strobe, latch low length byte -> S_LEN1.
  - S_LEN1: on strobe, latch high length byte. If count==0 -> S_DONE, else -> S_DATA.
  - S_DATA: shift bytes in; byte counter runs 0..3.
    - When the 4th byte is accepted at cycle t: at t+1 r_we=1, r_wdata=assembled word, r_addr=word index.
    - Word index increments after each write.
    - After the write of word count-1 -> S_DONE (or S_CSUM when CHECKSUM_EN is defined).
  - S_DONE: r_done=1 from the cycle after the final r_we pulse (or the cycle after S_LEN1 when count==0).
    - r_proc_rst=0 in the same cycle, unless r_err=1.
    - All further strobes are ignored; leaving S_DONE requires reset.
- r_we is never high for two consecutive cycles. Strobes may arrive back-to-back, one per cycle, with no loss.
- Overflow (count > MAX_WORDS):
  - Words with index >= MAX_WORDS are assembled and consumed but not written; r_we stays 0 for them.
  - r_err is set when the first such word completes.
  - Load still finishes in S_DONE with r_done=1, and r_proc_rst stays 1.
- r_addr never wraps; writes are suppressed instead.
- Gaps of any length between strobes are legal; there is no timeout.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data word, state S_CSUM expects one extra byte equal to the XOR of all data bytes (length bytes excluded; checksum is 0x00 when count==0).
  - Match -> S_DONE, processor released.
  - Mismatch -> r_err=1, S_DONE, r_proc_rst held at 1.
- Not defined: no S_CSUM state and no checksum byte; S_DATA goes straight to S_DONE.

Decomposition:
- Shared package: state encodings (S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE), LEN_BYTES=2, WORD_BYTES=4.
- Sub-module m_word_assembler: 32-bit little-endian shift register plus 2-bit byte counter. Outputs the word and a one-cycle word-complete strobe. Cleared by reset.
- The top block contains the FSM, address/word counters, overflow logic and checksum.

Test Plan:
- Bytes 02 00 | 20 00 00 00 | 00 10 08 20 -> r_we pulses: addr 0 data 0x00000020, then addr 1 data 0x20081000. r_done=1 and r_proc_rst=0 one cycle after the second pulse; r_err=0.
- Bytes 00 00 -> no r_we; r_done=1 and r_proc_rst=0 the cycle after the second byte. Subsequent bytes cause no writes.
- ADDR_W=2, count=5, five words back-to-back on consecutive cycles -> writes to addrs 0..3 only; r_err=1 after the fifth word; r_done=1; r_proc_rst stays 1.
- Count=3; reset pulsed low after 6 data bytes; then full stream 01 00 AA BB CC DD -> single write addr 0 data 0xDDCCBBAA; no write from the aborted load.
- CHECKSUM_EN, count=1, word 11 22 33 44, checksum 44 -> released. Same stream with checksum 45 -> r_err=1, r_proc_rst=1, r_done=1.
- Strobes spaced 1, 3 and 17 cycles apart -> identical write sequence to back-to-back delivery.
